// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, mid-bit sample points and parity helper for the UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] MID_BIT   = 4'd15;

    function automatic logic parity_calc(input logic [7:0] data, input logic bit8, input logic odd_n_even);
        return ^(bit8 ? data : {1'b0, data[6:0]}) ^ odd_n_even;
    endfunction

endpackage

// File: rtl/uart_rx_holding_reg.sv
// uart_rx_holding_reg: received-byte holding register with valid, overflow and sticky error flags,
// resolving a consumer read that lands on the same edge as a frame completion.
module uart_rx_holding_reg #(
    parameter bit SYNC_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       complete,
    input  logic [7:0] data_in,
    input  logic       par_bad,
    input  logic       stop_bit,
    input  logic       read_rx_byte,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overflow,
    output logic       parity_err,
    output logic       framing_err
);

    logic       arst_n, srst;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overflow_q, overflow_d;
    logic       parity_err_q, parity_err_d;
    logic       framing_err_q, framing_err_d;

    assign arst_n = SYNC_RESET ? 1'b1 : reset_n;
    assign srst   = SYNC_RESET & ~reset_n;

    always_comb begin
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        overflow_d    = overflow_q;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        if (srst) begin
            rx_data_d     = '0;
            rx_valid_d    = 1'b0;
            overflow_d    = 1'b0;
            parity_err_d  = 1'b0;
            framing_err_d = 1'b0;
        end else if (complete) begin
            // a coincident read retires the old byte and its flags; only this frame's errors remain
            rx_data_d     = data_in;
            rx_valid_d    = 1'b1;
            overflow_d    = ~read_rx_byte & (overflow_q | rx_valid_q);
            parity_err_d  = (~read_rx_byte & parity_err_q) | par_bad;
            framing_err_d = (~read_rx_byte & framing_err_q) | ~stop_bit;
        end else if (read_rx_byte & rx_valid_q) begin
            rx_valid_d    = 1'b0;
            overflow_d    = 1'b0;
            parity_err_d  = 1'b0;
            framing_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            overflow_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            overflow_q    <= overflow_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign overflow    = overflow_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x-oversampled UART receive FSM (start detect, mid-bit sampling, parity, stop).
// Define UART_RX_MAJORITY_EN to decide each bit by a 3-sample majority instead of a single sample.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter bit SYNC_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overflow,
    output logic       parity_err,
    output logic       framing_err
);

    logic       arst_n, srst;
    state_e     state_q, state_d;
    logic [3:0] samp_cnt_q, samp_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_bad_q, par_bad_d;
    logic       samp, mid, last_bit, complete;

    assign arst_n = SYNC_RESET ? 1'b1 : reset_n;
    assign srst   = SYNC_RESET & ~reset_n;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    assign hist_d = srst ? 2'b00 : baud_clock ? {hist_q[0], rx} : hist_q;
    // the two previous ticks plus the current one form the three-sample vote
    assign samp   = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) hist_q <= 2'b00;
        else         hist_q <= hist_d;
    end
`else
    assign samp = rx;
`endif

    assign mid      = samp_cnt_q == ((state_q == START) ? MID_START : MID_BIT);
    assign last_bit = bit_cnt_q == (bit8 ? 3'd7 : 3'd6);

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        complete   = 1'b0;
        if (srst) begin
            state_d    = IDLE;
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            par_bad_d  = 1'b0;
        end else if (baud_clock) begin
            samp_cnt_d = samp_cnt_q + 4'd1;
            case (state_q)
                IDLE: begin
                    samp_cnt_d = '0;
                    if (!rx) begin
                        state_d   = START;
                        par_bad_d = 1'b0;
                    end
                end
                START: if (mid) begin
                    state_d    = samp ? IDLE : DATA;
                    samp_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
                DATA: if (mid) begin
                    // 7-bit frames shift in at bit 6 so the byte lands right-aligned with bit 7 clear
                    shift_d   = bit8 ? {samp, shift_q[7:1]} : {1'b0, samp, shift_q[6:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) state_d = parity_en ? PARITY : STOP;
                end
                PARITY: if (mid) begin
                    par_bad_d = samp != parity_calc(shift_q, bit8, odd_n_even);
                    state_d   = STOP;
                end
                STOP: if (mid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
        end
    end

    uart_rx_holding_reg #(.SYNC_RESET(SYNC_RESET)) u_hold (
        .clk          (clk),
        .reset_n      (reset_n),
        .complete     (complete),
        .data_in      ({bit8 & shift_q[7], shift_q[6:0]}),
        .par_bad      (par_bad_q),
        .stop_bit     (samp),
        .read_rx_byte (read_rx_byte),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .overflow     (overflow),
        .parity_err   (parity_err),
        .framing_err  (framing_err)
    );

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: scoreboard bench; frames are built bit-by-bit on the line and expected bytes queued.
module tb_uart_rx_sampler;

    logic       clk = 1'b0, reset_n = 1'b1, baud_clock = 1'b0, rx = 1'b1;
    logic       bit8 = 1'b1, parity_en = 1'b0, odd_n_even = 1'b0, read_rx_byte = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, overflow, parity_err, framing_err;

    typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
    exp_t sb[$];
    int   checks = 0, failures = 0, bp = 4;
    bit   auto_read = 1'b0, pv = 1'b0;

    uart_rx_sampler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .baud_clock   (baud_clock),
        .rx           (rx),
        .bit8         (bit8),
        .parity_en    (parity_en),
        .odd_n_even   (odd_n_even),
        .read_rx_byte (read_rx_byte),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .overflow     (overflow),
        .parity_err   (parity_err),
        .framing_err  (framing_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
        end
    endfunction

    task automatic cyc(input bit b, input bit r);
        @(posedge clk);
        #1;
        baud_clock   = b;
        read_rx_byte = r | (auto_read & rx_valid);
    endtask

    task automatic tick(input bit r = 1'b0, input bit lat = 1'b0);
        cyc(1'b1, r);
        if (lat) begin
            @(negedge clk);
            chk("latency_before", {7'b0, rx_valid}, 8'd0);
        end
        cyc(1'b0, 1'b0);
        if (lat) begin
            @(negedge clk);
            chk("latency_after", {7'b0, rx_valid}, 8'd1);
        end
        repeat (bp - 2) cyc(1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] d, input bit b8, input bit pen, input bit odd, input bit pb,
                        input bit stop, input bit rd, input bit lat, input bit push, input int glitch);
        logic [7:0] dm;
        logic       bits[$];
        dm         = b8 ? d : {1'b0, d[6:0]};
        bit8       = b8;
        parity_en  = pen;
        odd_n_even = odd;
        if (push)
            sb.push_back('{d: dm, pe: pen && ((($countones(dm) + int'(pb) + int'(odd)) % 2) == 1), fe: !stop});
        bits.push_back(1'b0);
        for (int i = 0; i < (b8 ? 8 : 7); i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pb);
        foreach (bits[w])
            for (int t = 0; t < 16; t++) begin
                rx = (glitch >= 0 && w == glitch + 1 && t == 8) ? 1'b1 : bits[w];
                tick();
            end
        rx = stop;
        repeat (8) tick();
        tick(rd, lat);
        rx = 1'b1;
        repeat (10) tick();
    endtask

    task automatic read_and_check_clear(input string nm);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        @(negedge clk);
        chk({nm, "_valid"}, {7'b0, rx_valid}, 8'd0);
        chk({nm, "_flags"}, {5'b0, overflow, parity_err, framing_err}, 8'd0);
    endtask

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (rx_valid && !pv) begin
                if (sb.size() == 0) chk("unexpected_byte", {7'b0, rx_valid}, 8'd0);
                else begin
                    e = sb.pop_front();
                    chk("sb_data", rx_data, e.d);
                    chk("sb_parity_err", {7'b0, parity_err}, {7'b0, e.pe});
                    chk("sb_framing_err", {7'b0, framing_err}, {7'b0, e.fe});
                    chk("sb_overflow", {7'b0, overflow}, 8'd0);
                end
            end
            pv = rx_valid;
        end
    end

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) cyc(1'b0, 1'b0);
        @(negedge clk);
        chk("rst_data", rx_data, 8'd0);
        chk("rst_valid", {7'b0, rx_valid}, 8'd0);
        chk("rst_flags", {5'b0, overflow, parity_err, framing_err}, 8'd0);
        reset_n   = 1'b1;
        auto_read = 1'b1;
        send(8'hA5, 1, 0, 0, 0, 1, 0, 1, 1, -1);
        read_and_check_clear("read_when_empty");
        send(8'h41, 0, 1, 0, 0, 1, 0, 0, 1, -1);
        send(8'h41, 0, 1, 0, 1, 1, 0, 0, 1, -1);
        rx = 1'b0;
        repeat (5) tick();
        rx = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        chk("glitch_valid", {7'b0, rx_valid}, 8'd0);
        chk("glitch_flags", {5'b0, overflow, parity_err, framing_err}, 8'd0);
        auto_read = 1'b0;
        send(8'h3C, 1, 0, 0, 0, 0, 0, 0, 1, -1);
        @(negedge clk);
        chk("framing_held", {6'b0, rx_valid, framing_err}, 8'd3);
        read_and_check_clear("framing_read");
        send(8'h11, 1, 0, 0, 0, 1, 0, 0, 1, -1);
        send(8'h22, 1, 0, 0, 0, 1, 0, 0, 0, -1);
        @(negedge clk);
        chk("ovf_data", rx_data, 8'h22);
        chk("ovf_flags", {6'b0, rx_valid, overflow}, 8'd3);
        read_and_check_clear("ovf_read");
        send(8'h11, 1, 0, 0, 0, 1, 0, 0, 1, -1);
        send(8'h22, 1, 0, 0, 0, 1, 1, 0, 0, -1);
        @(negedge clk);
        chk("collide_data", rx_data, 8'h22);
        chk("collide_flags", {6'b0, rx_valid, overflow}, 8'd2);
        read_and_check_clear("collide_read");
        send(8'h77, 1, 0, 0, 0, 1, 0, 0, 1, -1);
        rx = 1'b0;
        repeat (16) tick();
        rx = 1'b1;
        repeat (56) tick();
        reset_n = 1'b0;
        repeat (2) cyc(1'b0, 1'b0);
        @(negedge clk);
        chk("midrst_data", rx_data, 8'd0);
        chk("midrst_flags", {4'b0, rx_valid, overflow, parity_err, framing_err}, 8'd0);
        reset_n   = 1'b1;
        auto_read = 1'b1;
        send(8'h5A, 1, 0, 0, 0, 1, 0, 0, 1, -1);
`ifdef UART_RX_MAJORITY_EN
        send(8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 2);
`endif
        for (int n = 0; n < 16; n++) begin
            bp = $urandom_range(3, 6);
            send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, 0, 0, 1, -1);
        end
        repeat (20) cyc(1'b0, 1'b0);
        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
